// File: rtl/vec_norm_if.sv
// Handshake bundle between the sample pipeline, vec_norm_ctrl and the sqrt unit.
// master = vec_norm_ctrl side, slave = environment (pipeline + sqrt) side.
interface vec_norm_if #(
    parameter int ELEM_W = 16
);
    logic [ELEM_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       sq_data;
    logic              sq_valid;
    logic              sq_ready;
    logic [31:0]       sq_result;
    logic [31:0]       norm_out;
    logic              norm_valid;
    logic              norm_sat;
    logic              busy;

    modport master (
        input  in_data, in_valid, sq_ready, sq_result,
        output in_ready, sq_data, sq_valid, norm_out, norm_valid, norm_sat, busy
    );

    modport slave (
        output in_data, in_valid, sq_ready, sq_result,
        input  in_ready, sq_data, sq_valid, norm_out, norm_valid, norm_sat, busy
    );
endinterface

// File: rtl/vec_norm_ctrl.sv
// Accumulates saturating sum of squares over N_ELEMS components, hands it to the
// sqrt unit over a level valid/ready handshake and publishes the returned norm.
module vec_norm_ctrl #(
    parameter int ELEM_W  = 16,
    parameter int N_ELEMS = 3
) (
    input logic        clock,
    input logic        reset,
    vec_norm_if.master bus
);
    localparam int CNT_W = (N_ELEMS > 1) ? $clog2(N_ELEMS) : 1;
    localparam int SQ_W  = 2 * ELEM_W;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_ELEMS - 1);

    typedef enum logic [1:0] {ACCUM, REQ, RELEASE} state_t;
    state_t state, state_nxt;

    logic [31:0]       acc;
    logic              sat;
    logic [CNT_W-1:0]  cnt;
    logic [31:0]       sq_data;
    logic              sq_valid;
    logic [31:0]       norm_out;
    logic              norm_valid;
    logic              norm_sat;

    logic signed [ELEM_W-1:0] elem;
    logic signed [SQ_W-1:0]   prod;
    logic [32:0]              sum;
    logic [31:0]              sum_sat;
    logic                     sum_ovf;
    logic                     accept, capture, release_done;

    // Operands are sign-extended before the multiply so -2^(W-1) squares correctly.
    assign elem    = $signed(bus.in_data);
    assign prod    = SQ_W'(elem) * SQ_W'(elem);
    assign sum     = {1'b0, acc} + {{(33-SQ_W){1'b0}}, prod};
    assign sum_ovf = sum[32];
    assign sum_sat = sum_ovf ? 32'hFFFF_FFFF : sum[31:0];

    always_ff @(posedge clock) begin
        if (reset) state <= ACCUM;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        accept       = 1'b0;
        capture      = 1'b0;
        release_done = 1'b0;
        case (state)
            ACCUM: if (bus.in_valid) begin
                accept = 1'b1;
                if (cnt == LAST) state_nxt = REQ;
            end
            REQ: if (bus.sq_ready) begin
                capture   = 1'b1;
                state_nxt = RELEASE;
            end
            // Responder must see valid low and drop ready before we re-arm.
            RELEASE: if (!bus.sq_ready) begin
                release_done = 1'b1;
                state_nxt    = ACCUM;
            end
            default: state_nxt = ACCUM;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            acc        <= '0;
            sat        <= 1'b0;
            cnt        <= '0;
            sq_data    <= '0;
            sq_valid   <= 1'b0;
            norm_out   <= '0;
            norm_valid <= 1'b0;
            norm_sat   <= 1'b0;
        end else begin
            norm_valid <= capture;
            if (accept) begin
                acc <= sum_sat;
                sat <= sat | sum_ovf;
                if (cnt == LAST) begin
                    cnt      <= '0;
                    sq_data  <= sum_sat;
                    sq_valid <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
            if (capture) begin
                norm_out <= bus.sq_result;
                norm_sat <= sat;
                sq_valid <= 1'b0;
            end
            if (release_done) begin
                acc <= '0;
                sat <= 1'b0;
            end
        end
    end

    assign bus.in_ready   = (state == ACCUM);
    assign bus.busy       = (state != ACCUM) || (cnt != '0);
    assign bus.sq_data    = sq_data;
    assign bus.sq_valid   = sq_valid;
    assign bus.norm_out   = norm_out;
    assign bus.norm_valid = norm_valid;
    assign bus.norm_sat   = norm_sat;
endmodule
